// File: rtl/ir_seq_ctrl.sv
// Instruction register, sequence counter and start/stop flip-flop for the
// basic-computer control unit, with combinational opcode and one-hot timing outputs.
module ir_seq_ctrl #(
    parameter int IR_W = 16,
    parameter int SC_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [IR_W-1:0]       bus_in,
    input  logic                  ir_ld,
    input  logic                  sc_inr,
    input  logic                  sc_clr,
    input  logic                  start,
    input  logic                  hlt,
    output logic [IR_W-1:0]       ir_out,
    output logic [2:0]            opcode,
    output logic                  i_bit,
    output logic [SC_W-1:0]       sc_out,
    output logic [(1<<SC_W)-1:0]  t,
    output logic                  running
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ir_out <= '0;
        end else if (ir_ld) begin
            ir_out <= bus_in;
        end
    end

    // running is the pre-edge value, so hlt with sc_inr still counts this edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sc_out <= '0;
        end else if (sc_clr) begin
            sc_out <= '0;
        end else if (sc_inr && running) begin
            sc_out <= sc_out + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            running <= 1'b1;
        end else if (hlt) begin
            running <= 1'b0;
        end else if (start) begin
            running <= 1'b1;
        end
    end

    assign opcode = ir_out[IR_W-2:IR_W-4];
    assign i_bit  = ir_out[IR_W-1];

    always_comb begin
        t         = '0;
        t[sc_out] = 1'b1;
    end

endmodule

// File: tb/tb_ir_seq_ctrl.sv
// Directed bench for ir_seq_ctrl: a reference model pushes expected register
// state into a queue per stimulus step; DUT outputs are popped and compared.
module tb_ir_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] bus_in;
    logic        ir_ld, sc_inr, sc_clr, start, hlt;
    logic [15:0] ir_out;
    logic [2:0]  opcode;
    logic        i_bit;
    logic [3:0]  sc_out;
    logic [15:0] t;
    logic        running;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] ir;
        logic [3:0]  sc;
        logic        run;
    } exp_t;

    exp_t        q[$];
    logic [15:0] m_ir;
    logic [3:0]  m_sc;
    logic        m_run;

    ir_seq_ctrl #(.IR_W(16), .SC_W(4)) dut (
        .clk(clk), .rst(rst), .bus_in(bus_in), .ir_ld(ir_ld),
        .sc_inr(sc_inr), .sc_clr(sc_clr), .start(start), .hlt(hlt),
        .ir_out(ir_out), .opcode(opcode), .i_bit(i_bit),
        .sc_out(sc_out), .t(t), .running(running)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_model;
        exp_t e;
        e.ir  = m_ir;
        e.sc  = m_sc;
        e.run = m_run;
        q.push_back(e);
    endtask

    task automatic pop_compare(input string tag);
        exp_t        e;
        logic [15:0] exp_t_vec;
        if (q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s: observed empty scoreboard expected entry", tag);
        end else begin
            e = q.pop_front();
            exp_t_vec = 16'h0001 << e.sc;
            chk({tag, ".ir"},     32'(ir_out),  32'(e.ir));
            chk({tag, ".opcode"}, 32'(opcode),  32'(e.ir[14:12]));
            chk({tag, ".i_bit"},  32'(i_bit),   32'(e.ir[15]));
            chk({tag, ".sc"},     32'(sc_out),  32'(e.sc));
            chk({tag, ".t"},      32'(t),       32'(exp_t_vec));
            chk({tag, ".run"},    32'(running), 32'(e.run));
        end
    endtask

    task automatic step(input string tag, input logic [15:0] b, input logic ld,
                        input logic inr, input logic clr, input logic st, input logic h);
        @(negedge clk);
        bus_in = b; ir_ld = ld; sc_inr = inr; sc_clr = clr; start = st; hlt = h;
        if (ld) m_ir = b;
        if (clr)              m_sc = 4'd0;
        else if (inr && m_run) m_sc = m_sc + 4'd1;
        if (h)       m_run = 1'b0;
        else if (st) m_run = 1'b1;
        push_model();
        @(posedge clk);
        #1;
        pop_compare(tag);
    endtask

    task automatic model_reset;
        m_ir = '0; m_sc = '0; m_run = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        bus_in = '0; ir_ld = 0; sc_inr = 0; sc_clr = 0; start = 0; hlt = 0;
        model_reset();
        #12;
        rst = 1'b0;
        push_model();
        pop_compare("por");

        // put non-reset state in, then reset between edges
        step("pre_ld", 16'hF7A5, 1, 1, 0, 0, 0);
        step("pre_inr", 16'h0000, 0, 1, 0, 0, 1);
        @(negedge clk);
        ir_ld = 0; sc_inr = 0; hlt = 0;
        #2 rst = 1'b1;
        #1;
        model_reset();
        push_model();
        pop_compare("midrst");
        chk("midrst.t_const", 32'(t), 32'h0001);
        rst = 1'b0;

        // 17 increments: 1..15, wrap to 0, then 1
        for (int i = 0; i < 17; i++) begin
            step("inr", 16'h0000, 0, 1, 0, 0, 0);
            if (i == 14) chk("t_at_15", 32'(t), 32'h8000);
            if (i == 15) chk("t_wrap", 32'(t), 32'h0001);
        end
        chk("sc_after17", 32'(sc_out), 32'd1);

        step("clr0", 16'h0000, 0, 0, 1, 0, 0);
        for (int i = 0; i < 5; i++) step("to5", 16'h0000, 0, 1, 0, 0, 0);
        chk("sc_is5", 32'(sc_out), 32'd5);
        step("clr_wins", 16'h0000, 0, 1, 1, 0, 0);
        chk("clr_wins.t", 32'(t), 32'h0001);

        step("ld_b123", 16'hB123, 1, 0, 0, 0, 0);
        chk("ld.i_bit", 32'(i_bit), 32'd1);
        chk("ld.opcode", 32'(opcode), 32'd3);

        step("clr5", 16'h0000, 0, 0, 1, 0, 0);
        step("inr1", 16'h0000, 0, 1, 0, 0, 0);
        step("inr2", 16'h0000, 0, 1, 0, 0, 0);
        step("hlt_inr", 16'h0000, 0, 1, 0, 0, 1);
        chk("hlt_inr.sc", 32'(sc_out), 32'd3);
        chk("hlt_inr.run", 32'(running), 32'd0);
        for (int i = 0; i < 3; i++) step("frozen", 16'h0000, 0, 1, 0, 0, 0);
        chk("frozen.sc", 32'(sc_out), 32'd3);
        step("ld_halted", 16'h5E01, 1, 0, 0, 0, 0);
        step("start_inr", 16'h0000, 0, 1, 0, 1, 0);
        chk("start_inr.sc", 32'(sc_out), 32'd3);
        step("resume", 16'h0000, 0, 1, 0, 0, 0);
        chk("resume.sc", 32'(sc_out), 32'd4);

        step("hlt_start", 16'h0000, 0, 0, 0, 1, 1);
        chk("hlt_start.run", 32'(running), 32'd0);
        step("clr_halted", 16'h0000, 0, 0, 1, 0, 0);
        chk("clr_halted.sc", 32'(sc_out), 32'd0);

        step("restart", 16'h0000, 0, 0, 0, 1, 0);
        step("inr_a", 16'h0000, 0, 1, 0, 0, 0);
        step("inr_b", 16'h0000, 0, 1, 0, 0, 0);
        step("fetch_clr", 16'h6ABC, 1, 1, 1, 0, 0);
        chk("fetch_clr.opcode", 32'(opcode), 32'd6);
        chk("fetch_clr.t", 32'(t), 32'h0001);
        step("hold", 16'hFFFF, 0, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
